// File: rtl/ps2_pkg.sv
// PS/2 keyboard receiver shared definitions.
// Prefix bytes, common key codes, FSM state enum, parity helper.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;

  localparam logic [7:0] PS2_UP    = 8'h75;
  localparam logic [7:0] PS2_DOWN  = 8'h72;
  localparam logic [7:0] PS2_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_RIGHT = 8'h74;
  localparam logic [7:0] PS2_1     = 8'h16;
  localparam logic [7:0] PS2_2     = 8'h1E;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    DECODE
  } ps2_state_e;

  // Odd parity over data byte plus parity bit.
  function automatic logic odd_ok(
    input logic [7:0] b,
    input logic       p
  );
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioning: 2-flop synchronisers, clock glitch filter,
// falling-edge pulse. Ports: clk, reset, ps2_clk, ps2_data in;
// data_s (synchronised data), fall (1-cycle filtered clk 1->0) out.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] CNT_LAST = FW'(FILTER_LEN - 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_f;
  logic [FW-1:0] r_cnt;
  logic          r_fall;
  logic          w_clk_s;

  assign w_clk_s = r_clk_sync[1];
  assign data_s  = r_dat_sync[1];
  assign fall    = r_fall;

  // The filtered level flips on the FILTER_LEN-th consecutive
  // sample that disagrees with it; any agreeing sample restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_f    <= 1'b1;
      r_cnt      <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
      r_fall     <= 1'b0;
      if (w_clk_s == r_clk_f) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_clk_f <= w_clk_s;
        r_cnt   <= '0;
        r_fall  <= ~w_clk_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_kb_receiver.sv
// PS/2 keyboard receiver: frame FSM, parity/stop check, timeout,
// E0/F0 prefix stripping. Ports: clk, reset, ps2_clk, ps2_data in;
// NewKB strobe, KB_DAT[7:0], KB_EXT, frame_err strobe out.
module ps2_kb_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       NewKB,
  output logic [7:0] KB_DAT,
  output logic       KB_EXT,
  output logic       frame_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

  logic       w_data;
  logic       w_fall;

  ps2_state_e r_state;
  ps2_state_e w_next;

  logic [7:0]    r_shift;
  logic [2:0]    r_bits;
  logic          r_par;
  logic          r_ext;
  logic          r_brk;
  logic [CW-1:0] r_to;

  logic w_timeout;
  logic w_adv;
  logic w_stop_ok;
  logic w_err;
  logic w_is_ext;
  logic w_is_brk;
  logic w_make;
  logic w_rel;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_s   (w_data),
    .fall     (w_fall)
  );

  // Timeout wins over a coincident fall: that edge is dropped.
  assign w_timeout = (r_state != IDLE) && (r_to == TO_MAX);
  assign w_adv     = w_fall && !w_timeout;
  assign w_stop_ok = w_data && odd_ok(r_shift, r_par);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_timeout) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_fall && !w_data) w_next = DATA;
        DATA:    if (w_fall && r_bits == 3'd7) w_next = PARITY;
        PARITY:  if (w_fall) w_next = STOP;
        STOP:    if (w_fall) w_next = w_stop_ok ? DECODE : IDLE;
        DECODE:  w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_err    = w_timeout ||
               (r_state == STOP && w_fall && !w_stop_ok);
    w_is_ext = (r_state == DECODE) && (r_shift == PS2_EXT);
    w_is_brk = (r_state == DECODE) && (r_shift == PS2_BRK);
    w_make   = (r_state == DECODE) && !w_is_ext &&
               !w_is_brk && !r_brk;
    w_rel    = (r_state == DECODE) && !w_is_ext &&
               !w_is_brk && r_brk;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_bits  <= '0;
      r_par   <= 1'b0;
    end else if (w_adv) begin
      if (r_state == IDLE) r_bits <= '0;
      if (r_state == DATA) begin
        r_shift <= {w_data, r_shift[7:1]};
        r_bits  <= r_bits + 1'b1;
      end
      if (r_state == PARITY) r_par <= w_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to <= '0;
    end else if (r_state == IDLE || w_fall) begin
      r_to <= '0;
    end else if (r_to != TO_MAX) begin
      r_to <= r_to + 1'b1;
    end
  end

  // A failed frame drops pending prefixes so the next byte
  // cannot inherit them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_err || w_rel) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_is_ext) begin
      r_ext <= 1'b1;
    end else if (w_is_brk) begin
      r_brk <= 1'b1;
    end else if (w_make) begin
      r_ext <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      NewKB     <= 1'b0;
      KB_DAT    <= 8'h00;
      KB_EXT    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      NewKB     <= w_make;
      frame_err <= w_err;
      if (w_make) begin
        KB_DAT <= r_shift;
        KB_EXT <= r_ext;
      end
    end
  end

endmodule
